// File: rtl/shift_issue_stage.sv
// shift_issue_stage
//   Execute-entry stage in front of the barrel shifter. Decodes MIPS R-type
//   shift instructions (SLL/SRL/SRA/SLLV/SRLV/SRAV) at accept time and hands
//   the decoded operands to the shifter through a 2-entry valid/ready FIFO.
//   Non-shift instructions pass through with sh_ops 0 (shifter outputs 0).
//
// Ports
//   clk, rst          clock, synchronous active-high reset (priority over flush)
//   flush             drop all buffered entries and any same-cycle input
//   in_valid/in_ready upstream handshake; in_ready depends on registered state only
//   instr, rs_val, rt_val  instruction word and register operands
//   out_valid/out_ready    shifter-side handshake
//   in, shamt, sh_ops, rd, is_shift  head-entry payload, all 0 while empty
module shift_issue_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] in,
    output logic [4:0]  shamt,
    output logic [1:0]  sh_ops,
    output logic [4:0]  rd,
    output logic        is_shift
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OPS_W   = 2;
    localparam int unsigned CNT_W   = 2;

    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] EMPTY = CNT_W'(0);

    // Shifter opcode encoding
    localparam logic [OPS_W-1:0] OPS_NONE = OPS_W'(0);
    localparam logic [OPS_W-1:0] OPS_SRL  = OPS_W'(1);
    localparam logic [OPS_W-1:0] OPS_SRA  = OPS_W'(2);
    localparam logic [OPS_W-1:0] OPS_SLL  = OPS_W'(3);

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        logic [OPS_W-1:0]   ops;
        logic [REG_W-1:0]   rd;
        logic               is_shift;
    } entry_t;

    entry_t           dec;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Instruction bits and rs bits the decoder never looks at
    logic unused_bits;
    assign unused_bits = ^{instr[25:16], rs_val[31:5]};

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Decode of the incoming instruction; operands captured as decoded fields
    always_comb begin
        dec          = '0;
        dec.data     = rt_val;
        dec.rd       = instr[15:11];
        if (instr[31:26] == 6'd0) begin
            case (instr[5:0])
                FN_SLL: begin
                    dec.ops      = OPS_SLL;
                    dec.shamt    = instr[10:6];
                    dec.is_shift = 1'b1;
                end
                FN_SRL: begin
                    dec.ops      = OPS_SRL;
                    dec.shamt    = instr[10:6];
                    dec.is_shift = 1'b1;
                end
                FN_SRA: begin
                    dec.ops      = OPS_SRA;
                    dec.shamt    = instr[10:6];
                    dec.is_shift = 1'b1;
                end
                FN_SLLV: begin
                    dec.ops      = OPS_SLL;
                    dec.shamt    = rs_val[4:0];
                    dec.is_shift = 1'b1;
                end
                FN_SRLV: begin
                    dec.ops      = OPS_SRL;
                    dec.shamt    = rs_val[4:0];
                    dec.is_shift = 1'b1;
                end
                FN_SRAV: begin
                    dec.ops      = OPS_SRA;
                    dec.shamt    = rs_val[4:0];
                    dec.is_shift = 1'b1;
                end
                default: begin
                    dec.ops      = OPS_NONE;
                end
            endcase
        end
    end

    // FIFO next state: head slot drives the outputs directly, tail is the
    // second entry. An emptied head is cleared so the payload reads 0.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + CNT_W'(1);
                if (count_q == EMPTY) begin
                    head_d = dec;
                end else begin
                    tail_d = dec;
                end
            end
            2'b01: begin
                count_d = count_q - CNT_W'(1);
                head_d  = (count_q == FULL) ? tail_q : '0;
                tail_d  = '0;
            end
            2'b11: begin
                // Only reachable with one entry: new entry replaces the head
                head_d = dec;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State and registered handshake flags
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q   <= EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            in_ready  <= (count_d != FULL);
            out_valid <= (count_d != EMPTY);
        end
    end

    assign in       = head_q.data;
    assign shamt    = head_q.shamt;
    assign sh_ops   = head_q.ops;
    assign rd       = head_q.rd;
    assign is_shift = head_q.is_shift;

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Execute-entry stage that sits directly upstream of the barrel shifter. Decodes MIPS R-type shift instructions (SLL/SRL/SRA/SLLV/SRLV/SRAV), selects the shift amount and source operand, and presents them to the shifter through a 2-entry valid/ready buffer. Non-shift instructions pass through with shifter opcode 0, so the shifter outputs 0 for them. Absorbs one cycle of downstream stall without dropping or reordering instructions.

## Interface
- DEPTH, 2, buffer entries (fixed at 2; other values unsupported)
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all buffered entries and of any same-cycle input
- in_valid  input  1  upstream presents an instruction
- in_ready  output  1  stage can accept this cycle
- instr  input  32  instruction word
- rs_val  input  32  rs register value
- rt_val  input  32  rt register value
- out_valid  output  1  head entry valid
- out_ready  input  1  shifter side consumes head this cycle
- in  output  32  shifter data operand (rt_val)
- shamt  output  5  shift amount
- sh_ops  output  2  3 = logical left, 1 = logical right, 2 = arithmetic right, 0 = no shift (shifter output 0)
- rd  output  5  destination register, instr[15:11]
- is_shift  output  1  head entry is one of the six shift instructions

## Operation
- Decode is applied only when instr[31:26] = 0. funct = instr[5:0]:
  - 0x00 SLL: sh_ops 3, shamt instr[10:6]
  - 0x02 SRL: sh_ops 1, shamt instr[10:6]
  - 0x03 SRA: sh_ops 2, shamt instr[10:6]
  - 0x04 SLLV: sh_ops 3, shamt rs_val[4:0]
  - 0x06 SRLV: sh_ops 1, shamt rs_val[4:0]
  - 0x07 SRAV: sh_ops 2, shamt rs_val[4:0]
- Any other opcode or funct: sh_ops 0, shamt 0, is_shift 0. in, rd and the accept/ordering behaviour are unchanged.
- instr = 0 decodes as SLL with rd 0, so is_shift is 1.
- Decode happens at accept. The buffer stores decoded fields {in, shamt, sh_ops, rd, is_shift}, not raw operands.
- The buffer is a FIFO with count 0..2:
  - push = in_valid && in_ready && !flush
  - pop = out_valid && out_ready && !flush
- in_ready = (count != 2), a function of registered count only. There is no combinational path from out_ready.
- out_valid = (count != 0).
- While out_valid = 0, payload outputs (in, shamt, sh_ops, rd, is_shift) are 0.
- Simultaneous push and pop:
  - count 1: count stays 1; the new entry becomes head on the next cycle.
  - count 0: push only, because pop requires out_valid.
- flush: count becomes 0 on the next edge. The same-cycle push is dropped and the same-cycle pop is not counted.
- rst has priority over flush.

## Timing
- Reset values: count 0, out_valid 0, in_ready 1, and all payload outputs 0.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (out_valid 1 in cycle N+1). There is no bypass path.
- Throughput: 1 instruction/cycle while out_ready is held high.
- Stall: with out_ready 0, two instructions are accepted and then in_ready drops to 0. When out_ready rises, in_ready returns to 1 one cycle later.
- Order is strictly FIFO. Payload is held stable while out_valid && !out_ready.
- Reset or flush during a stall: after the edge, out_valid is 0 and in_ready is 1. Entries held before reset or flush never appear.

## Test plan
- Decode: instr SLL rd=5 shamt=4, rt_val 5, out_ready 1 -> next cycle in=5, shamt=4, sh_ops=3, rd=5, is_shift=1. Repeat for SRL (sh_ops 1) and SRA (sh_ops 2).
- Variable shift: SRAV with rs_val 0x0000_0123, rt_val 0xFFFF_1111 -> shamt=3 (rs_val[4:0]), sh_ops=2, in=0xFFFF_1111. ADD funct 0x20 -> sh_ops=0, shamt=0, is_shift=0.
- Back-pressure: out_ready 0, send A, B, C on consecutive cycles:
  - A and B are accepted; in_ready is 0 in the cycle C is offered, so C stalls.
  - Raise out_ready -> outputs A then B then C, with no loss or duplication.
- Full-rate streaming: 8 shift instructions back-to-back with out_ready 1 -> 8 consecutive out_valid cycles after 1-cycle latency, in order. count never exceeds 1.
- Flush with count 2 and in_valid 1 in the same cycle -> next cycle out_valid 0 and in_ready 1. None of the three instructions is ever output.
- Reset asserted mid-stall with count 2 -> next cycle all outputs are at their reset values. The first post-reset instruction is output alone.
